serial_logic_unit: RTL and testbench

- Bit-serial initiator for the team's 1-bit logic cell.
- Captures two WIDTH-bit operands and a 2-bit op code on a start handshake.
- Drives the cell one bit per clock, LSB first, and collects the result bits into a register.
- Pulses done when the result is complete; sits between the control/datapath test harness and the logic cell.

---
 rtl/serial_logic_unit_pkg.sv | 16 +
 rtl/serial_logic_unit_if.sv | 35 +++
 rtl/serial_logic_unit_cl.sv | 23 ++
 rtl/serial_logic_unit.sv | 100 ++++++++++
 tb/tb_serial_logic_unit.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_logic_unit_pkg.sv
// Shared constants for the bit-serial logic unit: op codes and FSM
// state encodings used by the cell, the controller and the bench.
package serial_logic_unit_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_XOR = 2'b00;
    localparam op_t OP_AND = 2'b01;
    localparam op_t OP_OR  = 2'b10;
    localparam op_t OP_NOT = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/serial_logic_unit_if.sv
// Request/result bundle of the serial logic unit.
// master: drives start/a/b/op, observes busy/done/result[/zero].
// slave : the unit itself. zero exists with SERIAL_LOGIC_ZERO_FLAG_EN.
interface serial_logic_unit_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    logic             zero;

    modport master (
        output start, a, b, op,
        input  busy, done, result, zero
    );
    modport slave (
        input  start, a, b, op,
        output busy, done, result, zero
    );
`else
    modport master (
        output start, a, b, op,
        input  busy, done, result
    );
    modport slave (
        input  start, a, b, op,
        output busy, done, result
    );
`endif
endinterface

// File: rtl/serial_logic_unit_cl.sv
// 1-bit logic cell cl: out = f(a, b) selected by S.
// Ports: out (1), a (1), b (1), S (2): 00 XOR, 01 AND, 10 OR, 11 NOT a.
module cl
    import serial_logic_unit_pkg::*;
(
    output logic       out,
    input  logic       a,
    input  logic       b,
    input  logic [1:0] S
);

    always_comb begin
        out = 1'b0;
        unique case (S)
            OP_XOR:  out = a ^ b;
            OP_AND:  out = a & b;
            OP_OR:   out = a | b;
            OP_NOT:  out = ~a;
            default: out = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_logic_unit.sv
// Bit-serial initiator: captures a/b/op on start, drives cell cl LSB
// first one bit per clock, shifts results into an accumulator, pulses
// done when complete.
// Ports: clk, reset_l (async active-low), bus (serial_logic_unit_if.slave:
// start, a, b, op in; busy, done, result out; zero out when
// SERIAL_LOGIC_ZERO_FLAG_EN is defined).
module serial_logic_unit
    import serial_logic_unit_pkg::*;
#(
    parameter int WIDTH = 4
)
(
    input  logic               clk,
    input  logic               reset_l,
    serial_logic_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [1:0]       r_opr;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;

    logic             w_cell;
    logic [WIDTH-1:0] w_sr_next;
    logic             w_last;

    cl u_cl (
        .out (w_cell),
        .a   (r_sa[0]),
        .b   (r_sb[0]),
        .S   (r_opr)
    );

    // Cell output enters at the MSB so after WIDTH shifts the LSB-first
    // result bits line up with their operand positions.
    assign w_sr_next = {w_cell, r_sr[WIDTH-1:1]};
    assign w_last    = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state  <= ST_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_opr    <= '0;
            r_sr     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_sa    <= bus.a;
                        r_sb    <= bus.b;
                        r_opr   <= bus.op;
                        r_sr    <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sr  <= w_sr_next;
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_sr_next;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = (r_state != ST_IDLE);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.result = r_result;

`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
    logic r_zero;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_zero <= 1'b1;
        end else if (r_state == ST_RUN && w_last) begin
            r_zero <= ~|w_sr_next;
        end
    end

    assign bus.zero = r_zero;
`endif

endmodule

// File: tb/tb_serial_logic_unit.sv
// Self-checking bench for serial_logic_unit (WIDTH=4).
// Expected results are queued at start and popped on done.
module tb_serial_logic_unit;
    import serial_logic_unit_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic reset_l;

    always #5 clk = ~clk;

    serial_logic_unit_if #(.WIDTH(W)) bus ();

    serial_logic_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (bus)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    function automatic logic [W-1:0] model(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [1:0]   op
    );
        case (op)
            OP_XOR:  return a ^ b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return ~a;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [1:0]   op
    );
        exp_t e;
        e.res  = model(a, b, op);
        e.zero = (e.res == '0);
        sb_q.push_back(e);
    endtask

    // Drives one start cycle; returns at the cycle after the start edge.
    task automatic start_op(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [1:0]   op
    );
        bus.a     = a;
        bus.b     = b;
        bus.op    = op;
        bus.start = 1'b1;
        push_op(a, b, op);
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset_l   = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.op    = '0;
        repeat (2) step();
        n_cmp++;
        if ({bus.busy, bus.done, bus.result} !== {2'b00, {W{1'b0}}}) begin
            n_mis++;
            $display("FAIL reset_outs got %b%b %b want 00 0000",
                     bus.busy, bus.done, bus.result);
        end
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        n_cmp++;
        if (bus.zero !== 1'b1) begin
            n_mis++;
            $display("FAIL reset_zero got %b want 1", bus.zero);
        end
`endif
        reset_l = 1'b1;
        repeat (2) step();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_mis++;
            $display("FAIL idle_no_start busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_ops();
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] prev;
        exp_t e;
        int c;
        int nb;
        va = 4'b1100;
        vb = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            prev = bus.result;
            start_op(va, vb, 2'(k));
            c  = 0;
            nb = 0;
            while (c < 20) begin
                c++;
                if (bus.busy === 1'b1) nb++;
                if (bus.done === 1'b1) break;
                n_cmp++;
                if (bus.result !== prev) begin
                    n_mis++;
                    $display("FAIL run_hold op%0d got %b want %b",
                             k, bus.result, prev);
                end
                step();
            end
            n_cmp++;
            if (c != 5 || bus.done !== 1'b1) begin
                n_mis++;
                $display("FAIL done_lat op%0d got %0d want 5", k, c);
            end
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_mis++;
                $display("FAIL sb_empty op%0d", k);
            end else begin
                e = sb_q.pop_front();
                if (bus.result !== e.res) begin
                    n_mis++;
                    $display("FAIL op%0d result got %b want %b",
                             k, bus.result, e.res);
                end
            end
            step();
            n_cmp++;
            if (nb != 5 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                n_mis++;
                $display("FAIL busy_len op%0d got %0d busy=%b done=%b want 5 0 0",
                         k, nb, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_zero_flag();
        logic [1:0] ops [2];
        exp_t e;
        int c;
        ops[0] = OP_AND;
        ops[1] = OP_OR;
        for (int k = 0; k < 2; k++) begin
            start_op(4'b1010, 4'b0101, ops[k]);
            c = 1;
            while (bus.done !== 1'b1 && c < 20) begin
                step();
                c++;
            end
            n_cmp++;
            if (bus.done !== 1'b1) begin
                n_mis++;
                $display("FAIL zero_done k%0d got 0 want 1", k);
            end
            e = sb_q.pop_front();
            n_cmp++;
            if (bus.result !== e.res) begin
                n_mis++;
                $display("FAIL zero_res k%0d got %b want %b",
                         k, bus.result, e.res);
            end
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
            n_cmp++;
            if (bus.zero !== e.zero) begin
                n_mis++;
                $display("FAIL zero_flag k%0d got %b want %b",
                         k, bus.zero, e.zero);
            end
`endif
            step();
        end
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int c;
        int nd;
        start_op(4'b1100, 4'b1010, OP_XOR);
        bus.a     = 4'b1111;
        bus.b     = 4'b1111;
        bus.op    = OP_XOR;
        bus.start = 1'b1;
        step();
        step();
        bus.start = 1'b0;
        c = 3;
        while (bus.done !== 1'b1 && c < 20) begin
            step();
            c++;
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.done !== 1'b1 || bus.result !== e.res) begin
            n_mis++;
            $display("FAIL busy_ignore got %b want %b", bus.result, e.res);
        end
        nd = 0;
        repeat (12) begin
            step();
            if (bus.done === 1'b1) nd++;
        end
        n_cmp++;
        if (nd != 0) begin
            n_mis++;
            $display("FAIL busy_ignore_done got %0d want 0", nd);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic [1:0]   vo [3];
        int t [3];
        exp_t e;
        int cyc;
        int nd;
        va[0] = 4'b1100; vb[0] = 4'b1010; vo[0] = OP_OR;
        va[1] = 4'b0110; vb[1] = 4'b0011; vo[1] = OP_AND;
        va[2] = 4'b1001; vb[2] = 4'b0000; vo[2] = OP_NOT;
        bus.a     = va[0];
        bus.b     = vb[0];
        bus.op    = vo[0];
        bus.start = 1'b1;
        push_op(va[0], vb[0], vo[0]);
        cyc = 0;
        nd  = 0;
        while (nd < 3 && cyc < 60) begin
            step();
            cyc++;
            if (bus.done === 1'b1) begin
                t[nd] = cyc;
                e = sb_q.pop_front();
                n_cmp++;
                if (bus.result !== e.res) begin
                    n_mis++;
                    $display("FAIL b2b_res%0d got %b want %b",
                             nd, bus.result, e.res);
                end
                nd++;
                if (nd < 3) begin
                    bus.a  = va[nd];
                    bus.b  = vb[nd];
                    bus.op = vo[nd];
                    push_op(va[nd], vb[nd], vo[nd]);
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        n_cmp++;
        if (nd != 3) begin
            n_mis++;
            $display("FAIL b2b_count got %0d want 3", nd);
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_cmp++;
                if (t[i] - t[i-1] != W + 2) begin
                    n_mis++;
                    $display("FAIL b2b_gap%0d got %0d want %0d",
                             i, t[i] - t[i-1], W + 2);
                end
            end
        end
        sb_q.delete();
        repeat (3) step();
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        int c;
        start_op(4'b1100, 4'b1010, OP_OR);
        step();
        #2;
        reset_l = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.result} !== {2'b00, {W{1'b0}}}) begin
            n_mis++;
            $display("FAIL mid_reset got %b%b %b want 00 0000",
                     bus.busy, bus.done, bus.result);
        end
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
        n_cmp++;
        if (bus.zero !== 1'b1) begin
            n_mis++;
            $display("FAIL mid_reset_zero got %b want 1", bus.zero);
        end
`endif
        void'(sb_q.pop_front());
        step();
        reset_l = 1'b1;
        step();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_mis++;
            $display("FAIL post_reset got busy=%b done=%b want 0 0",
                     bus.busy, bus.done);
        end
        start_op(4'b0011, 4'b0101, OP_XOR);
        c = 1;
        while (bus.done !== 1'b1 && c < 20) begin
            step();
            c++;
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.done !== 1'b1 || bus.result !== e.res) begin
            n_mis++;
            $display("FAIL after_reset_op got %b want %b",
                     bus.result, e.res);
        end
        step();
    endtask

    task automatic test_operand_change();
        exp_t e;
        int c;
        start_op(4'b1100, 4'b1010, OP_AND);
        c = 1;
        while (bus.done !== 1'b1 && c < 20) begin
            bus.a  = ~bus.a;
            bus.b  = bus.b + 4'd3;
            bus.op = bus.op + 2'd1;
            step();
            c++;
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.done !== 1'b1 || bus.result !== e.res) begin
            n_mis++;
            $display("FAIL operand_change got %b want %b",
                     bus.result, e.res);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_ops();
        test_zero_flag();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_op();
        test_operand_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
